// File: rtl/keystream_fifo.sv
// keystream_fifo: splits IN_WIDTH keystream blocks into OUT_WIDTH words (lowest slice first)
// and buffers them in a 2^DEPTH_LOG2-word circular buffer with registered one-word reads.
module keystream_fifo #(
  parameter int IN_WIDTH   = 512,
  parameter int OUT_WIDTH  = 128,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_w_en,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic                 o_in_ready,
  input  logic                 i_r_en,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_r_valid,
  input  logic                 i_flush,
  output logic [DEPTH_LOG2:0]  o_count,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_err
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         DEPTH_W = CW'(DEPTH);
  localparam logic [CW-1:0]         RATIO_W = CW'(RATIO);
  localparam logic [CW-1:0]         ONE_C   = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_P   = DEPTH_LOG2'(1);

  logic [IN_WIDTH-1:0]   stream_q, stream_d;
  logic [CW-1:0]         left_q, left_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [OUT_WIDTH-1:0]  data_q, data_d;
  logic                  rvld_q, rvld_d;
  logic                  err_q, err_d;
  logic [OUT_WIDTH-1:0]  mem_q [DEPTH];

  logic drain, rd, accept, mem_we;

  always_comb begin
    drain    = (left_q != '0) && (count_q != DEPTH_W);
    rd       = i_r_en && (count_q != '0);
    accept   = i_w_en && (left_q == '0);
    mem_we   = drain && !i_flush;
    stream_d = stream_q;
    left_d   = left_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    data_d   = data_q;
    rvld_d   = 1'b0;
    err_d    = err_q;
    if (i_flush) begin
      stream_d = '0;
      left_d   = '0;
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      data_d   = '0;
      err_d    = 1'b0;
    end else begin
      // Accept and drain are mutually exclusive: accept needs an idle serializer.
      if (accept) begin
        stream_d = i_data;
        left_d   = RATIO_W;
      end else if (drain) begin
        stream_d = stream_q >> OUT_WIDTH;
        left_d   = left_q - ONE_C;
        wptr_d   = wptr_q + ONE_P;
      end
      rvld_d = rd;
      if (rd) begin
        data_d = mem_q[rptr_q];
        rptr_d = rptr_q + ONE_P;
      end
      if (drain && !rd) begin
        count_d = count_q + ONE_C;
      end else if (rd && !drain) begin
        count_d = count_q - ONE_C;
      end
      if ((i_w_en && !accept) || (i_r_en && !rd)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stream_q <= '0;
      left_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      data_q   <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      stream_q <= stream_d;
      left_q   <= left_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: a slot is only read after a drain has written it.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= stream_q[OUT_WIDTH-1:0];
    end
  end

  assign o_in_ready = (left_q == '0);
  assign o_data     = data_q;
  assign o_r_valid  = rvld_q;
  assign o_count    = count_q;
  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == DEPTH_W);
  assign o_err      = err_q;

endmodule

// File: tb/tb_keystream_fifo.sv
// Bench for keystream_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the serializer and word buffer.
module tb_keystream_fifo;
  localparam int IW    = 512;
  localparam int OW    = 128;
  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int RATIO = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic          flush = 1'b0;
  logic [IW-1:0] din = '0;
  logic          in_ready, r_valid, empty, full, err;
  logic [OW-1:0] dout;
  logic [DL:0]   count;

  keystream_fifo #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH_LOG2(DL)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_w_en(w_en), .i_data(din), .o_in_ready(in_ready),
    .i_r_en(r_en), .o_data(dout), .o_r_valid(r_valid), .i_flush(flush),
    .o_count(count), .o_empty(empty), .o_full(full), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [OW-1:0] m_fifo[$];
  logic [OW-1:0] m_pend[$];
  logic [OW-1:0] m_data;
  logic          m_vld;
  logic          m_err;

  task automatic chk(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pend.delete();
    m_data = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock edge of the reference: everything is decided on pre-edge occupancy.
  task automatic model_edge();
    int cnt;
    bit rdy;
    cnt = m_fifo.size();
    rdy = (m_pend.size() == 0);
    if (flush) begin
      model_reset();
    end else begin
      if ((w_en && !rdy) || (r_en && cnt == 0)) m_err = 1'b1;
      if (r_en && cnt > 0) begin
        m_data = m_fifo.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (!rdy && cnt < DEPTH) m_fifo.push_back(m_pend.pop_front());
      if (w_en && rdy) begin
        for (int i = 0; i < RATIO; i++) m_pend.push_back(din[i*OW +: OW]);
      end
    end
  endtask

  task automatic compare_all();
    chk("count", OW'(count), OW'(m_fifo.size()));
    chk("empty", OW'(empty), OW'(m_fifo.size() == 0));
    chk("full", OW'(full), OW'(m_fifo.size() == DEPTH));
    chk("in_ready", OW'(in_ready), OW'(m_pend.size() == 0));
    chk("err", OW'(err), OW'(m_err));
    chk("r_valid", OW'(r_valid), OW'(m_vld));
    chk("data", dout, m_data);
  endtask

  task automatic cyc(input bit w, input bit r, input bit f, input logic [IW-1:0] d);
    w_en  = w;
    r_en  = r;
    flush = f;
    din   = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    w_en  = 1'b0;
    r_en  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_blk(output logic [IW-1:0] b);
    for (int i = 0; i < IW/32; i++) b[i*32 +: 32] = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"}, dout, '0);
    chk({tag, "_valid"}, OW'(r_valid), '0);
    chk({tag, "_count"}, OW'(count), '0);
    chk({tag, "_empty"}, OW'(empty), OW'(1));
    chk({tag, "_full"}, OW'(full), '0);
    chk({tag, "_ready"}, OW'(in_ready), OW'(1));
    chk({tag, "_err"}, OW'(err), '0);
  endtask

  logic [IW-1:0] blk;

  initial begin
    model_reset();
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rstn = 1'b1;

    // Single block: words come out lowest slice first.
    blk = {128'h4, 128'h3, 128'h2, 128'h1};
    cyc(1'b1, 1'b0, 1'b0, blk);
    chk("sb_ready_low", OW'(in_ready), '0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("sb_count", OW'(count), OW'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk("sb_data", dout, OW'(i + 1));
      chk("sb_valid", OW'(r_valid), OW'(1));
    end
    idle(1);
    chk("sb_valid_drop", OW'(r_valid), '0);
    chk("sb_empty", OW'(empty), OW'(1));

    // Full and backpressure, then drain across the pointer wrap.
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk); idle(4);
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk); idle(4);
    chk("full_count", OW'(count), OW'(8));
    chk("full_flag", OW'(full), OW'(1));
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk); idle(3);
    chk("stall_ready", OW'(in_ready), '0);
    chk("stall_count", OW'(count), OW'(8));
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("stall_read_count", OW'(count), OW'(7));
    idle(1);
    chk("stall_refill", OW'(count), OW'(8));
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_empty", OW'(empty), OW'(1));

    // Simultaneous drain and read at count 4.
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk); idle(4);
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("simul_count", OW'(count), OW'(4));
    chk("simul_valid", OW'(r_valid), OW'(1));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, '0);

    // Misuse: read on empty, write while busy.
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("mis_rd_err", OW'(err), OW'(1));
    chk("mis_rd_valid", OW'(r_valid), '0);
    chk("mis_rd_count", OW'(count), '0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk);
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk);
    chk("mis_wr_err", OW'(err), OW'(1));
    idle(3);
    chk("mis_wr_count", OW'(count), OW'(4));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, '0);

    // Flush mid-drain with r_left=2 and count=5.
    cyc(1'b0, 1'b0, 1'b1, '0);
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk);
    idle(1); cyc(1'b0, 1'b1, 1'b0, '0); idle(2);
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk);
    idle(1); cyc(1'b1, 1'b0, 1'b0, blk);
    chk("pre_flush_count", OW'(count), OW'(5));
    chk("pre_flush_err", OW'(err), OW'(1));
    cyc(1'b1, 1'b1, 1'b1, blk);
    chk("flush_count", OW'(count), '0);
    chk("flush_ready", OW'(in_ready), OW'(1));
    chk("flush_err", OW'(err), '0);
    chk("flush_data", dout, '0);
    chk("flush_valid", OW'(r_valid), '0);
    blk = {128'hd, 128'hc, 128'hb, 128'ha};
    cyc(1'b1, 1'b0, 1'b0, blk); idle(4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk("post_flush_data", dout, OW'(10 + i));
    end

    // Asynchronous reset in the middle of a drain.
    rand_blk(blk); cyc(1'b1, 1'b0, 1'b0, blk); idle(2);
    cyc(1'b0, 1'b1, 1'b0, '0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_reset_vals("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    chk("post_rst_ready", OW'(in_ready), OW'(1));

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rand_blk(blk);
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
          ($urandom_range(0, 49) == 0), blk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
